// File: rtl/maze_solver_ctrl.sv
// Depth-first maze solver controller for a 16x16 one-bit maze memory.
// Marks visited cells, probes neighbours in order and backtracks via a move stack.
module maze_solver_ctrl #(
    parameter logic [3:0] START_X = 4'd0,
    parameter logic [3:0] START_Y = 4'd0,
    parameter logic [3:0] GOAL_X  = 4'd15,
    parameter logic [3:0] GOAL_Y  = 4'd15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       mem_dout,
    output logic [3:0] mem_x,
    output logic [3:0] mem_y,
    output logic       mem_rd,
    output logic       mem_wr,
    output logic       mem_din,
    output logic       busy,
    output logic       done,
    output logic       fail,
    output logic [7:0] path_len,
    input  logic [7:0] rd_idx,
    output logic [1:0] rd_dir
);
    typedef enum logic [2:0] {
        IDLE, MARK, PROBE, BACKTRACK, DONE, FAIL
    } state_t;

    state_t     state, state_n;
    logic [3:0] pos_x, pos_y, pos_x_n, pos_y_n;
    logic [1:0] dir, dir_n;
    logic [7:0] sp, sp_n;
    logic       push;
    logic [1:0] stack [256];
    logic [3:0] nb_x, nb_y;
    logic       nb_oob;
    logic [1:0] top_dir;
    logic [3:0] bk_x, bk_y;

    assign top_dir  = stack[sp - 8'd1];
    assign path_len = sp;
    assign rd_dir   = stack[rd_idx];
    assign busy     = (state == MARK) || (state == PROBE) || (state == BACKTRACK);
    assign done     = (state == DONE);
    assign fail     = (state == FAIL);

    always_comb begin
        nb_x   = pos_x;
        nb_y   = pos_y;
        nb_oob = 1'b0;
        unique case (dir)
            2'd0: begin
                nb_y   = pos_y - 4'd1;
                nb_oob = (pos_y == 4'd0);
            end
            2'd1: begin
                nb_x   = pos_x + 4'd1;
                nb_oob = (pos_x == 4'd15);
            end
            2'd2: begin
                nb_x   = pos_x - 4'd1;
                nb_oob = (pos_x == 4'd0);
            end
            2'd3: begin
                nb_y   = pos_y + 4'd1;
                nb_oob = (pos_y == 4'd15);
            end
        endcase
    end

    // Undo the popped move: step opposite to the stored direction.
    always_comb begin
        bk_x = pos_x;
        bk_y = pos_y;
        unique case (top_dir)
            2'd0: bk_y = pos_y + 4'd1;
            2'd1: bk_x = pos_x - 4'd1;
            2'd2: bk_x = pos_x + 4'd1;
            2'd3: bk_y = pos_y - 4'd1;
        endcase
    end

    always_comb begin
        state_n = state;
        pos_x_n = pos_x;
        pos_y_n = pos_y;
        dir_n   = dir;
        sp_n    = sp;
        push    = 1'b0;
        mem_x   = pos_x;
        mem_y   = pos_y;
        mem_rd  = 1'b0;
        mem_wr  = 1'b0;
        mem_din = 1'b0;
        unique case (state)
            IDLE, DONE, FAIL: begin
                if (start) begin
                    state_n = MARK;
                    pos_x_n = START_X;
                    pos_y_n = START_Y;
                    sp_n    = 8'd0;
                    dir_n   = 2'd0;
                end
            end
            MARK: begin
                mem_wr  = 1'b1;
                mem_din = 1'b1;
                if (pos_x == GOAL_X && pos_y == GOAL_Y) begin
                    state_n = DONE;
                end else begin
                    dir_n   = 2'd0;
                    state_n = PROBE;
                end
            end
            PROBE: begin
                if (!nb_oob) begin
                    mem_x  = nb_x;
                    mem_y  = nb_y;
                    mem_rd = 1'b1;
                end
                if (!nb_oob && !mem_dout) begin
                    push    = 1'b1;
                    sp_n    = sp + 8'd1;
                    pos_x_n = nb_x;
                    pos_y_n = nb_y;
                    state_n = MARK;
                end else if (dir != 2'd3) begin
                    dir_n = dir + 2'd1;
                end else begin
                    state_n = BACKTRACK;
                end
            end
            BACKTRACK: begin
                if (sp == 8'd0) begin
                    state_n = FAIL;
                end else begin
                    sp_n    = sp - 8'd1;
                    pos_x_n = bk_x;
                    pos_y_n = bk_y;
                    if (top_dir != 2'd3) begin
                        dir_n   = top_dir + 2'd1;
                        state_n = PROBE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            pos_x <= 4'd0;
            pos_y <= 4'd0;
            dir   <= 2'd0;
            sp    <= 8'd0;
        end else begin
            state <= state_n;
            pos_x <= pos_x_n;
            pos_y <= pos_y_n;
            dir   <= dir_n;
            sp    <= sp_n;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !rst) stack[sp] <= dir;
    end
endmodule

// File: tb/tb_maze_solver_ctrl.sv
// Bench for maze_solver_ctrl: directed scenarios plus random mazes
// checked against a DFS reference model over an image of the maze.
module tb_maze_solver_ctrl;
    localparam int N = 3;
    localparam int LIMIT = 4000;

    logic       clk = 1'b0;
    logic       rst;
    logic       start [N];
    logic       mem_dout [N];
    logic [3:0] mem_x [N];
    logic [3:0] mem_y [N];
    logic       mem_rd [N];
    logic       mem_wr [N];
    logic       mem_din [N];
    logic       busy [N];
    logic       done [N];
    logic       fail [N];
    logic [7:0] path_len [N];
    logic [7:0] rd_idx [N];
    logic [1:0] rd_dir [N];

    logic maze [N][256];
    logic img [N][256];
    logic load_req;

    int total = 0;
    int bad = 0;

    bit exp_ok;
    int exp_path [$];
    bit exp_mem [256];

    always #5 clk = ~clk;

    maze_solver_ctrl u0 (
        .clk(clk), .rst(rst), .start(start[0]), .mem_dout(mem_dout[0]),
        .mem_x(mem_x[0]), .mem_y(mem_y[0]), .mem_rd(mem_rd[0]),
        .mem_wr(mem_wr[0]), .mem_din(mem_din[0]), .busy(busy[0]),
        .done(done[0]), .fail(fail[0]), .path_len(path_len[0]),
        .rd_idx(rd_idx[0]), .rd_dir(rd_dir[0])
    );

    maze_solver_ctrl #(.GOAL_X(4'd0), .GOAL_Y(4'd1)) u1 (
        .clk(clk), .rst(rst), .start(start[1]), .mem_dout(mem_dout[1]),
        .mem_x(mem_x[1]), .mem_y(mem_y[1]), .mem_rd(mem_rd[1]),
        .mem_wr(mem_wr[1]), .mem_din(mem_din[1]), .busy(busy[1]),
        .done(done[1]), .fail(fail[1]), .path_len(path_len[1]),
        .rd_idx(rd_idx[1]), .rd_dir(rd_dir[1])
    );

    maze_solver_ctrl #(.GOAL_X(4'd0), .GOAL_Y(4'd0)) u2 (
        .clk(clk), .rst(rst), .start(start[2]), .mem_dout(mem_dout[2]),
        .mem_x(mem_x[2]), .mem_y(mem_y[2]), .mem_rd(mem_rd[2]),
        .mem_wr(mem_wr[2]), .mem_din(mem_din[2]), .busy(busy[2]),
        .done(done[2]), .fail(fail[2]), .path_len(path_len[2]),
        .rd_idx(rd_idx[2]), .rd_dir(rd_dir[2])
    );

    for (genvar g = 0; g < N; g++) begin : g_rd
        assign mem_dout[g] = maze[g][{mem_y[g], mem_x[g]}];
    end

    always @(posedge clk) begin
        for (int g = 0; g < N; g++) begin
            if (load_req) begin
                for (int k = 0; k < 256; k++) maze[g][k] = img[g][k];
            end else if (mem_wr[g]) begin
                maze[g][{mem_y[g], mem_x[g]}] = mem_din[g];
            end
        end
    end

    task automatic walls_all(input int u);
        for (int k = 0; k < 256; k++) img[u][k] = 1'b1;
    endtask

    task automatic open_cell(input int u, input int x, input int y);
        img[u][y * 16 + x] = 1'b0;
    endtask

    task automatic load();
        load_req = 1'b1;
        @(posedge clk);
        #1;
        load_req = 1'b0;
    endtask

    task automatic corridor_map();
        walls_all(0);
        for (int i = 0; i < 16; i++) begin
            open_cell(0, i, 0);
            open_cell(0, 15, i);
        end
        load();
    endtask

    // n = edge index (start edge = 1) at which done/fail is first seen.
    task automatic run(input int u, input int pulse_at,
                       output int n, output int bc, output int both);
        start[u] = 1'b1;
        @(posedge clk);
        #1;
        start[u] = 1'b0;
        n = 1;
        bc = 0;
        both = 0;
        while (!(done[u] || fail[u]) && n < LIMIT) begin
            if (busy[u]) bc++;
            if (mem_rd[u] && mem_wr[u]) both++;
            start[u] = (n == pulse_at);
            @(posedge clk);
            #1;
            n++;
        end
        start[u] = 1'b0;
        total++;
        if (!(done[u] || fail[u])) begin
            bad++;
            $display("FAIL timeout u%0d: got no done/fail after %0d cycles", u, n);
        end
    endtask

    task automatic ref_solve(input int u, input int gx, input int gy);
        int x, y, d, nx, ny;
        bit found;
        for (int k = 0; k < 256; k++) exp_mem[k] = img[u][k];
        exp_path.delete();
        x = 0;
        y = 0;
        nx = 0;
        ny = 0;
        forever begin
            exp_mem[y * 16 + x] = 1'b1;
            if (x == gx && y == gy) begin
                exp_ok = 1'b1;
                return;
            end
            d = 0;
            forever begin
                found = 1'b0;
                while (d < 4 && !found) begin
                    nx = x + ((d == 1) ? 1 : (d == 2) ? -1 : 0);
                    ny = y + ((d == 3) ? 1 : (d == 0) ? -1 : 0);
                    if (nx >= 0 && nx < 16 && ny >= 0 && ny < 16 &&
                        !exp_mem[ny * 16 + nx])
                        found = 1'b1;
                    else
                        d++;
                end
                if (found) break;
                if (exp_path.size() == 0) begin
                    exp_ok = 1'b0;
                    return;
                end
                d = exp_path.pop_back();
                x = x - ((d == 1) ? 1 : (d == 2) ? -1 : 0);
                y = y - ((d == 3) ? 1 : (d == 0) ? -1 : 0);
                d = d + 1;
            end
            exp_path.push_back(d);
            x = nx;
            y = ny;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int u = 0; u < N; u++) begin
            total++;
            if ({busy[u], done[u], fail[u], mem_rd[u], mem_wr[u], mem_din[u],
                 mem_x[u], mem_y[u], path_len[u]} !== 22'd0) begin
                bad++;
                $display("FAIL reset u%0d: got busy=%0b done=%0b fail=%0b x=%0d y=%0d len=%0d want all 0",
                         u, busy[u], done[u], fail[u], mem_x[u], mem_y[u], path_len[u]);
            end
        end
    endtask

    task automatic check_corridor_result(input string tag, input int n, input int bc);
        int miss;
        total++;
        if (n !== 122 || bc !== 121) begin
            bad++;
            $display("FAIL %s_timing: got done_edge=%0d busy=%0d want 122/121", tag, n, bc);
        end
        total++;
        if (done[0] !== 1'b1 || fail[0] !== 1'b0 || path_len[0] !== 8'd30) begin
            bad++;
            $display("FAIL %s_result: got done=%0b fail=%0b len=%0d want 1/0/30",
                     tag, done[0], fail[0], path_len[0]);
        end
        for (int i = 0; i < 30; i++) begin
            rd_idx[0] = 8'(i);
            #1;
            total++;
            if (rd_dir[0] !== ((i < 15) ? 2'd1 : 2'd3)) begin
                bad++;
                $display("FAIL %s_dir[%0d]: got %0d want %0d", tag, i, rd_dir[0],
                         (i < 15) ? 1 : 3);
            end
        end
        miss = 0;
        for (int i = 0; i < 16; i++)
            if (maze[0][i] !== 1'b1 || maze[0][i * 16 + 15] !== 1'b1) miss++;
        total++;
        if (miss != 0) begin
            bad++;
            $display("FAIL %s_marks: got %0d unmarked corridor cells want 0", tag, miss);
        end
    endtask

    task automatic test_corridor();
        int n, bc, both;
        corridor_map();
        run(0, 0, n, bc, both);
        check_corridor_result("corridor", n, bc);
        total++;
        if (both != 0) begin
            bad++;
            $display("FAIL rd_wr_excl: got %0d overlapping cycles want 0", both);
        end
    endtask

    task automatic test_dead_end();
        int n, bc, both;
        walls_all(0);
        open_cell(0, 0, 0);
        open_cell(0, 1, 0);
        load();
        run(0, 0, n, bc, both);
        total++;
        if (fail[0] !== 1'b1 || done[0] !== 1'b0 || path_len[0] !== 8'd0) begin
            bad++;
            $display("FAIL dead_end: got fail=%0b done=%0b len=%0d want 1/0/0",
                     fail[0], done[0], path_len[0]);
        end
        total++;
        if (n !== 13) begin
            bad++;
            $display("FAIL dead_end_edge: got %0d want 13", n);
        end
        total++;
        if (maze[0][1] !== 1'b1) begin
            bad++;
            $display("FAIL dead_end_mark: got %0b want 1", maze[0][1]);
        end
    endtask

    task automatic test_goal_near();
        int n, bc, both;
        walls_all(1);
        open_cell(1, 0, 0);
        open_cell(1, 1, 0);
        open_cell(1, 0, 1);
        ref_solve(1, 0, 1);
        load();
        run(1, 0, n, bc, both);
        rd_idx[1] = 8'd0;
        #1;
        total++;
        if (done[1] !== 1'b1 || path_len[1] !== 8'd1 || rd_dir[1] !== 2'd3) begin
            bad++;
            $display("FAIL goal_near: got done=%0b len=%0d dir0=%0d want 1/1/3",
                     done[1], path_len[1], rd_dir[1]);
        end
        total++;
        if (exp_ok !== 1'b1 || exp_path.size() != 1 || maze[1][1] !== 1'b1) begin
            bad++;
            $display("FAIL goal_near_model: got dead_end_mark=%0b want 1 (model ok=%0b len=%0d)",
                     maze[1][1], exp_ok, exp_path.size());
        end
    endtask

    task automatic test_goal_start();
        int n, bc, both;
        walls_all(2);
        open_cell(2, 0, 0);
        load();
        run(2, 0, n, bc, both);
        total++;
        if (n !== 2 || done[2] !== 1'b1 || path_len[2] !== 8'd0) begin
            bad++;
            $display("FAIL goal_start: got edge=%0d done=%0b len=%0d want 2/1/0",
                     n, done[2], path_len[2]);
        end
        total++;
        if (maze[2][0] !== 1'b1) begin
            bad++;
            $display("FAIL goal_start_mark: got %0b want 1", maze[2][0]);
        end
    endtask

    task automatic test_reset_mid();
        int n, bc, both;
        corridor_map();
        start[0] = 1'b1;
        @(posedge clk);
        #1;
        start[0] = 1'b0;
        repeat (11) @(posedge clk);
        #1;
        total++;
        if (busy[0] !== 1'b1 || mem_rd[0] !== 1'b1 || mem_x[0] !== 4'd4) begin
            bad++;
            $display("FAIL mid_probe: got busy=%0b rd=%0b x=%0d want 1/1/4",
                     busy[0], mem_rd[0], mem_x[0]);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        total++;
        if ({busy[0], done[0], fail[0], mem_rd[0], mem_wr[0], mem_din[0],
             mem_x[0], mem_y[0], path_len[0]} !== 22'd0) begin
            bad++;
            $display("FAIL mid_reset: got busy=%0b x=%0d y=%0d len=%0d want all 0",
                     busy[0], mem_x[0], mem_y[0], path_len[0]);
        end
        run(0, 0, n, bc, both);
        total++;
        if (fail[0] !== 1'b1 || done[0] !== 1'b0 || path_len[0] !== 8'd0 || n !== 7) begin
            bad++;
            $display("FAIL mid_rerun: got fail=%0b done=%0b len=%0d edge=%0d want 1/0/0/7",
                     fail[0], done[0], path_len[0], n);
        end
    endtask

    task automatic test_back_to_back();
        int n, bc, both;
        corridor_map();
        run(0, 50, n, bc, both);
        check_corridor_result("busy_start", n, bc);
        run(0, 0, n, bc, both);
        total++;
        if (fail[0] !== 1'b1 || done[0] !== 1'b0 || path_len[0] !== 8'd0) begin
            bad++;
            $display("FAIL restart_done: got fail=%0b done=%0b len=%0d want 1/0/0",
                     fail[0], done[0], path_len[0]);
        end
    endtask

    task automatic test_random();
        int n, bc, both, miss, dmiss;
        for (int t = 0; t < 20; t++) begin
            for (int k = 0; k < 256; k++)
                img[0][k] = ($urandom_range(0, 99) < 30) ? 1'b1 : 1'b0;
            img[0][255] = 1'b0;
            ref_solve(0, 15, 15);
            load();
            run(0, 0, n, bc, both);
            total++;
            if (done[0] !== exp_ok || fail[0] !== !exp_ok ||
                path_len[0] !== 8'(exp_path.size())) begin
                bad++;
                $display("FAIL rand%0d_result: got done=%0b len=%0d want %0b/%0d",
                         t, done[0], path_len[0], exp_ok, exp_path.size());
            end
            dmiss = 0;
            for (int i = 0; i < exp_path.size(); i++) begin
                rd_idx[0] = 8'(i);
                #1;
                if (rd_dir[0] !== 2'(exp_path[i])) dmiss++;
            end
            total++;
            if (dmiss != 0) begin
                bad++;
                $display("FAIL rand%0d_path: got %0d wrong directions want 0", t, dmiss);
            end
            miss = 0;
            for (int k = 0; k < 256; k++)
                if (maze[0][k] !== exp_mem[k]) miss++;
            total++;
            if (miss != 0 || both != 0) begin
                bad++;
                $display("FAIL rand%0d_mem: got %0d cell diffs, %0d rd/wr overlaps want 0/0",
                         t, miss, both);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        load_req = 1'b0;
        for (int u = 0; u < N; u++) begin
            start[u] = 1'b0;
            rd_idx[u] = 8'd0;
            for (int k = 0; k < 256; k++) img[u][k] = 1'b1;
        end
        test_reset();
        test_corridor();
        test_dead_end();
        test_goal_near();
        test_goal_start();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
